fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared fifo_sync write port
// Owner keeps the port for up to BURST_LEN accepted words; one ARB cycle between grants.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_wr_rdy,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id,
  output logic [15:0]                   stall_cnt
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

  typedef enum logic {ARB, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [IDW-1:0]  last_owner_q, last_owner_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic                  in_grant;
  logic                  owner_valid;
  logic                  fifo_open;
  logic                  xfer;
  logic [IDW-1:0]        pick_idx;
  logic [DATA_WIDTH-1:0] owner_data;

  function automatic logic [IDW-1:0] wrap_idx(input int v);
    return IDW'(v % NUM_REQ);
  endfunction

  assign in_grant    = (state_q == GRANT);
  assign owner_valid = req_valid[grant_id_q];
  assign fifo_open   = fifo_wr_rdy & ~fifo_almost_full;
  assign xfer        = in_grant & owner_valid & fifo_open;

  // Scan downward so the last hit is the first valid lane after last_owner.
  always_comb begin
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(int'(last_owner_q) + 1 + k)]) begin
        pick_idx = wrap_idx(int'(last_owner_q) + 1 + k);
      end
    end
  end

  always_comb begin
    owner_data = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        owner_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = xfer;
      end
    end
  end

  assign fifo_wr_en   = xfer;
  assign fifo_data_in = in_grant ? owner_data : '0;
  assign grant_valid  = in_grant;
  assign grant_id     = grant_id_q;
  assign stall_cnt    = stall_cnt_q;

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    case (state_q)
      ARB: begin
        if (|req_valid) begin
          state_d      = GRANT;
          grant_id_d   = pick_idx;
          last_owner_d = pick_idx;
          beat_cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_valid) begin
          state_d = ARB;
        end else if (!fifo_open) begin
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB;
      grant_id_q   <= '0;
      last_owner_q <= IDW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr_rdy;
  logic        fifo_almost_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] stall_cnt;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_wr_rdy      (fifo_wr_rdy),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_data_in     (fifo_data_in),
    .grant_valid      (grant_valid),
    .grant_id         (grant_id),
    .stall_cnt        (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       gv;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   sent [4]     = '{0, 0, 0, 0};
  int   exp_sent [4] = '{0, 0, 0, 0};
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [7:0] word_of(input int i, input int n);
    return 8'((i + 7) * 16 + ((n + 1) & 15));
  endfunction

  function automatic exp_t mk(input logic en, input logic gv, input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.en = en; e.gv = gv; e.id = id; e.data = data;
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Requester model: each lane presents its next word, advancing on an accepted handshake.
  for (genvar g = 0; g < 4; g++) begin : g_data
    assign req_data[g*8 +: 8] = word_of(g, sent[g]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) sent[i] <= sent[i] + 1;
    end
  end

  always @(negedge clk) begin
    if (!fifo_wr_rdy) check_val("wr_while_not_rdy", 32'(fifo_wr_en), 32'd0);
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check_val("grant_valid", 32'(grant_valid), 32'(mon_e.gv));
      check_val("fifo_wr_en", 32'(fifo_wr_en), 32'(mon_e.en));
      check_val("req_ready", 32'(req_ready), mon_e.en ? (32'd1 << mon_e.id) : 32'd0);
      check_val("fifo_data_in", 32'(fifo_data_in), 32'(mon_e.data));
      if (mon_e.gv) check_val("grant_id", 32'(grant_id), 32'(mon_e.id));
    end else begin
      check_val("idle_wr_en", 32'(fifo_wr_en), 32'd0);
      check_val("idle_req_ready", 32'(req_ready), 32'd0);
    end
  end

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 8'd0));
  endtask

  task automatic push_wr(input int id, input int n);
    repeat (n) begin
      exp_q.push_back(mk(1'b1, 1'b1, 2'(id), word_of(id, exp_sent[id])));
      exp_sent[id]++;
    end
  endtask

  task automatic push_hold(input int id, input int n);
    repeat (n) exp_q.push_back(mk(1'b0, 1'b1, 2'(id), word_of(id, exp_sent[id])));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    check_val({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check_val({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, "_data_in"}, 32'(fifo_data_in), 32'd0);
    check_val({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check_val({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 4'b0;
    fifo_wr_rdy = 1'b1;
    fifo_almost_full = 1'b0;
    #1;
    check_zero_outputs("reset");
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Requesters 0 and 2 continuously valid: 0,2,0 with one ARB cycle between bursts.
    req_valid = 4'b0101;
    push_idle(1); push_wr(0, 4); push_idle(1); push_wr(2, 4); push_idle(1); push_wr(0, 4);
    wait_drain(40);
    req_valid = 4'b0000;
    step(2);

    // Requester 3 sends two words then drops; burst ends early.
    do_reset();
    req_valid = 4'b1000;
    push_idle(1); push_wr(3, 2); push_hold(3, 1); push_idle(1);
    step(3);
    req_valid = 4'b0000;
    wait_drain(20);
    check_val("short_burst_stall", 32'(stall_cnt), 32'd0);

    // Almost-full for 3 cycles mid-burst; a non-owner lane toggles meanwhile.
    do_reset();
    req_valid = 4'b0010;
    push_idle(1); push_wr(1, 2); push_hold(1, 3); push_wr(1, 2); push_idle(1);
    step(3);
    fifo_almost_full = 1'b1;
    req_valid = 4'b0011;
    step(3);
    fifo_almost_full = 1'b0;
    req_valid = 4'b0010;
    step(2);
    req_valid = 4'b0000;
    wait_drain(20);
    check_val("almost_full_stall", 32'(stall_cnt), 32'd3);

    // FIFO full for 5 grant cycles; writes resume the cycle it opens.
    do_reset();
    req_valid = 4'b0001;
    fifo_wr_rdy = 1'b0;
    push_idle(1); push_hold(0, 5); push_wr(0, 4); push_idle(1);
    step(6);
    fifo_wr_rdy = 1'b1;
    step(4);
    req_valid = 4'b0000;
    wait_drain(20);
    check_val("full_stall", 32'(stall_cnt), 32'd5);

    // Reset mid-cycle during requester 2's third beat; the cut word is resent later.
    do_reset();
    req_valid = 4'b0100;
    push_idle(1); push_wr(2, 2); push_idle(1);
    step(3);
    #2 reset = 1'b1;
    #1 check_zero_outputs("mid_reset");
    step(1);
    reset = 1'b0;
    req_valid = 4'b0101;
    push_idle(1); push_wr(0, 4); push_idle(1); push_wr(2, 4); push_idle(1);
    step(10);
    req_valid = 4'b0000;
    wait_drain(20);

    // Stall counter saturation.
    do_reset();
    req_valid = 4'b0001;
    fifo_wr_rdy = 1'b0;
    step(65535);
    check_val("stall_near_sat", 32'(stall_cnt), 32'hFFFE);
    step(1);
    check_val("stall_sat", 32'(stall_cnt), 32'hFFFF);
    step(4465);
    check_val("stall_hold_sat", 32'(stall_cnt), 32'hFFFF);
    check_val("stall_grant_valid", 32'(grant_valid), 32'd1);

    do_reset();
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
